// File: rtl/traffic_control_pkg.sv
// traffic_control_pkg
//   Shared definitions for the highway / country-road traffic-light controller:
//   2-bit light codes, the FSM state encoding and the default phase delays.
package traffic_control_pkg;

    // Light codes driven on HWY_LIGHT / CT_LIGHT (2'd3 is never driven)
    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;

    // Controller states, named by (highway / country) lights:
    //   S0 GREEN/RED, S1 YELLOW/RED, S2 RED/RED, S3 RED/GREEN, S4 RED/YELLOW
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    // Default phase lengths in clock cycles (legal range 1..15)
    localparam int DEF_Y2R_DELAY = 3;
    localparam int DEF_R2G_DELAY = 2;

    localparam int TMR_W = 4;

endpackage

// File: rtl/tc_phase_timer.sv
// tc_phase_timer
//   4-bit loadable down-counter used to time the yellow and all-red phases.
//   Counts down to zero and holds there until the next load.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset, clears the count
//   load     - load load_val this cycle (has priority over counting)
//   load_val - value to load (phase length minus one)
//   zero     - count is zero
module tc_phase_timer
    import traffic_control_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero
);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - TMR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/traffic_control.sv
// traffic_control
//   Moore FSM traffic-light controller. The highway is green by default; the
//   country road gets green only while CT_SENSOR is high, with timed yellow
//   (Y2R_DELAY cycles) and all-red (R2G_DELAY cycles) phases in between.
// Ports:
//   CLOCK     - system clock, rising edge
//   RESET     - synchronous active-high reset, forces highway green
//   CT_SENSOR - 1 = vehicle waiting on the country road
//   HWY_LIGHT - highway light code (RED=0, YELLOW=1, GREEN=2)
//   CT_LIGHT  - country-road light code
module traffic_control
    import traffic_control_pkg::*;
#(
    parameter int Y2R_DELAY = DEF_Y2R_DELAY,
    parameter int R2G_DELAY = DEF_R2G_DELAY
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       CT_SENSOR,
    output logic [1:0] HWY_LIGHT,
    output logic [1:0] CT_LIGHT
);

    // Timer holds (length - 1) so the entry cycle counts as the first cycle
    localparam logic [TMR_W-1:0] Y2R_LOAD = TMR_W'(Y2R_DELAY - 1);
    localparam logic [TMR_W-1:0] R2G_LOAD = TMR_W'(R2G_DELAY - 1);

    state_t           state_q, state_d;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_zero;

    tc_phase_timer u_timer (
        .clk      (CLOCK),
        .rst      (RESET),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Next-state and timer-load logic
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            S0: begin
                if (CT_SENSOR) begin
                    state_d  = S1;
                    tmr_load = 1'b1;
                    tmr_val  = Y2R_LOAD;
                end
            end
            S1: begin
                if (tmr_zero) begin
                    state_d  = S2;
                    tmr_load = 1'b1;
                    tmr_val  = R2G_LOAD;
                end
            end
            S2: begin
                if (tmr_zero)
                    state_d = S3;
            end
            S3: begin
                if (!CT_SENSOR) begin
                    state_d  = S4;
                    tmr_load = 1'b1;
                    tmr_val  = Y2R_LOAD;
                end
            end
            S4: begin
                if (tmr_zero)
                    state_d = S0;
            end
            default: begin
                // Illegal encoding: recover to highway green with a clean timer
                state_d  = S0;
                tmr_load = 1'b1;
                tmr_val  = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET)
            state_q <= S0;
        else
            state_q <= state_d;
    end

    // Moore output decode straight from the state register
    always_comb begin
        HWY_LIGHT = RED;
        CT_LIGHT  = RED;
        case (state_q)
            S0: HWY_LIGHT = GREEN;
            S1: HWY_LIGHT = YELLOW;
            S2: ;
            S3: CT_LIGHT  = GREEN;
            S4: CT_LIGHT  = YELLOW;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_control.sv
// tb_traffic_control
//   Self-checking bench: two controllers (default delays and Y2R=1/R2G=4)
//   share one stimulus. Each is compared every cycle against a light-pair
//   reference model, plus directed edge-count expectations.
module tb_traffic_control;

    localparam logic [1:0] R = 2'd0;
    localparam logic [1:0] Y = 2'd1;
    localparam logic [1:0] G = 2'd2;

    typedef struct {
        logic [1:0] hwy;
        logic [1:0] ct;
        int         age;   // cycles already spent in the current phase
    } mdl_t;

    logic       clk;
    logic       rst;
    logic       sen;
    logic [1:0] hwy_a, ct_a, hwy_b, ct_b;

    int n_chk  = 0;
    int n_pass = 0;

    mdl_t ma, mb;

    traffic_control u_dut_a (
        .CLOCK     (clk),
        .RESET     (rst),
        .CT_SENSOR (sen),
        .HWY_LIGHT (hwy_a),
        .CT_LIGHT  (ct_a)
    );

    traffic_control #(.Y2R_DELAY(1), .R2G_DELAY(4)) u_dut_b (
        .CLOCK     (clk),
        .RESET     (rst),
        .CT_SENSOR (sen),
        .HWY_LIGHT (hwy_b),
        .CT_LIGHT  (ct_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference: phases identified by their light pair, timed by age
    function automatic mdl_t mdl_next(mdl_t m, logic r, logic s, int y2r, int r2g);
        mdl_t n = m;
        if (r) begin
            n.hwy = G; n.ct = R; n.age = 0;
            return n;
        end
        n.age = m.age + 1;
        if (m.hwy == G && m.ct == R) begin
            if (s) begin n.hwy = Y; n.age = 1; end
        end else if (m.hwy == Y) begin
            if (m.age == y2r) begin n.hwy = R; n.age = 1; end
        end else if (m.ct == R) begin
            if (m.age == r2g) begin n.ct = G; n.age = 1; end
        end else if (m.ct == G) begin
            if (!s) begin n.ct = Y; n.age = 1; end
        end else begin
            if (m.age == y2r) begin n.hwy = G; n.ct = R; n.age = 1; end
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        ma = mdl_next(ma, rst, sen, 3, 2);
        mb = mdl_next(mb, rst, sen, 1, 4);
        #1;
        chk("mdl_a_hwy", hwy_a, ma.hwy);
        chk("mdl_a_ct",  ct_a,  ma.ct);
        chk("mdl_b_hwy", hwy_b, mb.hwy);
        chk("mdl_b_ct",  ct_b,  mb.ct);
    endtask

    task automatic tick_exp(input logic [1:0] ha, input logic [1:0] ca,
                            input logic [1:0] hb, input logic [1:0] cb);
        tick();
        chk("dir_a_hwy", hwy_a, ha);
        chk("dir_a_ct",  ct_a,  ca);
        chk("dir_b_hwy", hwy_b, hb);
        chk("dir_b_ct",  ct_b,  cb);
    endtask

    initial begin
        ma = '{hwy: G, ct: R, age: 0};
        mb = '{hwy: G, ct: R, age: 0};
        rst = 1'b1;
        sen = 1'b0;

        // reset, then idle with sensor low
        repeat (2) tick_exp(G, R, G, R);
        rst = 1'b0;
        repeat (10) tick_exp(G, R, G, R);

        // full cycle, sensor held high from edge k
        sen = 1'b1;
        tick_exp(Y, R, Y, R);            // k
        tick_exp(Y, R, R, R);            // k+1
        tick_exp(Y, R, R, R);            // k+2
        tick_exp(R, R, R, R);            // k+3
        tick_exp(R, R, R, R);            // k+4
        tick_exp(R, G, R, G);            // k+5
        repeat (5) tick_exp(R, G, R, G);

        // return: sensor drops at edge m
        sen = 1'b0;
        tick_exp(R, Y, R, Y);            // m
        tick_exp(R, Y, G, R);            // m+1
        tick_exp(R, Y, G, R);            // m+2
        tick_exp(G, R, G, R);            // m+3
        repeat (3) tick_exp(G, R, G, R);

        // one-cycle sensor pulse
        sen = 1'b1;
        tick_exp(Y, R, Y, R);            // k
        sen = 1'b0;
        tick_exp(Y, R, R, R);            // k+1
        tick_exp(Y, R, R, R);            // k+2
        tick_exp(R, R, R, R);            // k+3
        tick_exp(R, R, R, R);            // k+4
        tick_exp(R, G, R, G);            // k+5: single green cycle
        tick_exp(R, Y, R, Y);            // k+6
        tick_exp(R, Y, G, R);            // k+7
        tick_exp(R, Y, G, R);            // k+8
        tick_exp(G, R, G, R);            // k+9
        repeat (2) tick_exp(G, R, G, R);

        // reset in the middle of the yellow phase
        sen = 1'b1;
        tick_exp(Y, R, Y, R);
        sen = 1'b0;
        rst = 1'b1;
        tick_exp(G, R, G, R);
        rst = 1'b0;
        repeat (5) tick_exp(G, R, G, R);
        sen = 1'b1;
        tick_exp(Y, R, Y, R);
        sen = 1'b0;
        tick_exp(Y, R, R, R);
        tick_exp(Y, R, R, R);
        tick_exp(R, R, R, R);

        // randomized: sticky sensor with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0)
                sen = ~sen;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
